// File: rtl/pc_sequencer_if.sv
// Fetch-redirect bus between the branch/resolve logic and the PC sequencer.
// The master side drives the branch decisions; the slave side is the sequencer.
interface pc_sequencer_if #(
    parameter int PC_WIDTH  = 32,
    parameter int OFF_WIDTH = 16
);
    logic                 stall;
    logic                 ShortBr_out;
    logic [OFF_WIDTH-1:0] ShortBrOffset;
    logic                 LongBr;
    logic [PC_WIDTH-1:0]  LongBrTarget;
    logic                 Call;
    logic                 Ret;
    logic                 halt;
    logic                 resume;
    logic [PC_WIDTH-1:0]  pc;
    logic                 pc_valid;
    logic                 flush;
    logic [PC_WIDTH-1:0]  LinkAddr;
    logic                 halted;
    logic                 ras_err;

    modport master (
        output stall, ShortBr_out, ShortBrOffset, LongBr, LongBrTarget,
               Call, Ret, halt, resume,
        input  pc, pc_valid, flush, LinkAddr, halted, ras_err
    );

    modport slave (
        input  stall, ShortBr_out, ShortBrOffset, LongBr, LongBrTarget,
               Call, Ret, halt, resume,
        output pc, pc_valid, flush, LinkAddr, halted, ras_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and fetch-redirect stage of the miniRISC core.
// Advances the fetch PC each cycle or redirects it on short/long branches,
// calls and returns (through a circular return-address stack) and HALT.
module pc_sequencer #(
    parameter int PC_WIDTH  = 32,
    parameter int OFF_WIDTH = 16,
    parameter int RAS_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] RAS_FULL = (PTR_W + 1)'(RAS_DEPTH);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc_r;
    logic [PC_WIDTH-1:0] pc_d;
    logic                pc_valid_r;
    logic                ex_valid;
    logic                ras_err_r;
    logic [PC_WIDTH-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W:0]      count;

    logic                accept;
    logic                take_halt;
    logic                take_ret;
    logic                take_long;
    logic                take_short;
    logic                taken;
    logic                do_push;
    logic                ras_empty;
    logic                ras_full;
    logic [PC_WIDTH-1:0] ras_top;
    logic [PC_WIDTH-1:0] off_ext;
    logic [PC_WIDTH-1:0] target;

    // Decode which redirect (if any) is accepted this cycle and its target address.
    always_comb begin
        accept     = (state == RUN) && ex_valid && !bus.stall;
        take_halt  = accept && bus.halt;
        take_ret   = accept && !bus.halt && bus.Ret;
        take_long  = accept && !bus.halt && !bus.Ret && bus.LongBr;
        take_short = accept && !bus.halt && !bus.Ret && !bus.LongBr && bus.ShortBr_out;
        taken      = take_ret || take_long || take_short;
        do_push    = take_long && bus.Call;
        ras_empty  = (count == '0);
        ras_full   = (count == RAS_FULL);
        ras_top    = ras[ptr - 1'b1];
        off_ext    = {{(PC_WIDTH - OFF_WIDTH){bus.ShortBrOffset[OFF_WIDTH-1]}}, bus.ShortBrOffset};
        target     = '0;
        if (take_ret) begin
            target = ras_empty ? '0 : ras_top;
        end else if (take_long) begin
            target = bus.LongBrTarget;
        end else if (take_short) begin
            target = pc_d + PC_WIDTH'(1) + off_ext;
        end
    end

    // Return-address storage; a push when full lands on the oldest slot because ptr wraps.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            ras[ptr] <= pc_d + PC_WIDTH'(1);
        end
    end

    // Sequencer state machine: PC advance, redirects, stall hold, HALT and RAS bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            pc_r       <= '0;
            pc_d       <= '0;
            pc_valid_r <= 1'b0;
            ex_valid   <= 1'b0;
            ras_err_r  <= 1'b0;
            ptr        <= '0;
            count      <= '0;
        end else if (state == HALT) begin
            if (bus.resume) begin
                state      <= RUN;
                pc_valid_r <= 1'b1;
                ex_valid   <= 1'b0;
            end
        end else if (bus.stall) begin
            pc_valid_r <= 1'b1;
        end else if (take_halt) begin
            state      <= HALT;
            pc_valid_r <= 1'b0;
            ex_valid   <= 1'b0;
        end else if (taken) begin
            pc_r       <= target;
            pc_d       <= pc_r;
            ex_valid   <= 1'b0;
            pc_valid_r <= 1'b1;
            if (do_push) begin
                ptr <= ptr + 1'b1;
                if (ras_full) begin
                    ras_err_r <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
            if (take_ret) begin
                if (ras_empty) begin
                    ras_err_r <= 1'b1;
                end else begin
                    ptr   <= ptr - 1'b1;
                    count <= count - 1'b1;
                end
            end
        end else begin
            pc_d       <= pc_r;
            ex_valid   <= pc_valid_r;
            pc_valid_r <= 1'b1;
            if (pc_valid_r) begin
                pc_r <= pc_r + PC_WIDTH'(1);
            end
        end
    end

    assign bus.pc       = pc_r;
    assign bus.pc_valid = pc_valid_r;
    assign bus.flush    = rst && (taken || take_halt);
    assign bus.LinkAddr = pc_d + PC_WIDTH'(1);
    assign bus.halted   = (state == HALT);
    assign bus.ras_err  = ras_err_r;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and fetch-redirect stage of the miniRISC core, directly downstream of the branch decider. Each cycle it either advances the fetch PC by one word, or redirects it. A redirect comes from the resolved short-branch decision (ShortBr_out), an unconditional long branch, or a call/return through a small return-address stack. On every taken redirect it issues a one-cycle flush that kills the wrong-path instruction fetched behind the branch.

## Interface
Parameters:
- PC_WIDTH, 32, word-address width of the PC.
- OFF_WIDTH, 16, width of the signed short-branch offset.
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low (rst==0 at a rising edge resets).
- stall  input  1  hold the PC and the resolve-stage PC; branch inputs ignored.
- ShortBr_out  input  1  short branch taken, from the branch decider.
- ShortBrOffset  input  OFF_WIDTH  signed word offset for the short branch.
- LongBr  input  1  unconditional branch to LongBrTarget.
- LongBrTarget  input  PC_WIDTH  absolute target word address.
- Call  input  1  with LongBr: also push the return address.
- Ret  input  1  branch to the popped return address.
- halt  input  1  HALT instruction resolved.
- resume  input  1  leave HALT.
- pc  output  PC_WIDTH  current fetch address.
- pc_valid  output  1  pc is a live fetch this cycle.
- flush  output  1  kill the instruction fetched at the previous pc.
- LinkAddr  output  PC_WIDTH  resolve-stage PC + 1 (return address).
- halted  output  1  sequencer is in HALT.
- ras_err  output  1  sticky; set on RAS overflow or underflow.

## Operation
- Internal registers:
  - pc_d: PC of the instruction in the resolve stage.
  - ex_valid: that instruction is live.
  - State register: RUN or HALT.
  - RAS: RAS_DEPTH × PC_WIDTH entries, with pointer and count.
- ex_valid is the previous cycle's pc_valid AND NOT the previous cycle's flush, held during stall.
- Branch, halt and call inputs are honoured only when ex_valid=1, stall=0 and state=RUN. Decode guarantees at most one of ShortBr_out/LongBr/Ret/halt per instruction.
- If more than one is asserted anyway, priority is halt > Ret > LongBr > ShortBr_out.
- Target computation, modulo 2^PC_WIDTH, wrap-around allowed with no error:
  - Short target = pc_d + 1 + sign_extend(ShortBrOffset).
  - Long target = LongBrTarget.
  - Ret target = RAS top.
- Taken redirect in RUN:
  - Next pc = target.
  - flush=1 in the same cycle as the accepted branch (combinational from the accepted condition).
  - pc_d ← pc, ex_valid ← 0.
- Not-taken, not-stalled cycle in RUN: pc ← pc + 1, pc_d ← pc.
- stall=1 in RUN: pc, pc_d, ex_valid and RAS held; flush=0.
- Call (LongBr & Call accepted):
  - Push pc_d + 1.
  - If the RAS is full, overwrite the oldest entry (circular), keep count = RAS_DEPTH, set ras_err.
- Ret accepted:
  - Pop; target is the top entry.
  - If the RAS is empty, the target is 0, the pointer is unchanged and ras_err is set.
- halt accepted:
  - State → HALT.
  - flush=1 that cycle.
  - pc frozen at its current value; pc_valid=0 and halted=1 from the next cycle.
- HALT state:
  - All branch and stall inputs ignored.
  - resume=1 → RUN next cycle, fetching from the frozen pc with pc_valid=1 and ex_valid=0.
- LinkAddr is always pc_d + 1.

## Timing
- Reset (rst==0 at an edge):
  - pc=0, pc_d=0, pc_valid=0, ex_valid=0, flush=0, halted=0, ras_err=0.
  - RAS count=0, pointer=0, state=RUN.
  - Reset mid-operation, including in HALT or during stall, takes effect at that edge and discards everything.
- First cycle after reset release: pc=0, pc_valid=1.
- Branch penalty: one bubble. The wrong-path instruction is fetched in the branch's resolve cycle and killed by flush; the target appears on pc the next cycle.
- flush never asserts while stall=1 or in HALT.
- Push and pop take effect at the accepting edge; the RAS top is readable in the following cycle.
- ras_err is cleared only by reset.

## Test plan
- Reset, then 4 free-running cycles → pc sequence 0,1,2,3 with pc_valid=1; flush=0 throughout.
- Short branch with pc_d=5, ShortBrOffset=-3 and ShortBr_out=1 → flush=1 that cycle, next pc=3, ex_valid=0 next cycle.
- Short branch with ShortBr_out=1 but stall=1 for 2 cycles, then released with ShortBr_out=0 → pc held for 2 cycles, no flush, then pc+1.
- LongBr+Call at pc_d=0x10, target 0x40; later Ret → LinkAddr=0x11, pc=0x40, then pc=0x11 after Ret; ras_err=0.
- 5 calls with RAS_DEPTH=4, then 5 returns → ras_err=1 after the 5th call. Returns yield the 4 most recent addresses, then target 0.
- halt at pc=0x22, assert resume 3 cycles later, then assert rst=0 mid-run → halted=1 and pc_valid=0 for 3 cycles. Resume fetches 0x22. Reset returns pc=0 and pc_valid=0 at that edge.
